// File: rtl/rr_mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
// Optional grant locking is enabled with RR_MUX_ARB_LOCK_EN (see rr_mux_arbiter).
package rr_mux_arb_pkg;

  localparam int unsigned DefN = 4;
  localparam int unsigned DefW = 2;
  // Upper bound on lane count supported by the rotate helpers.
  localparam int unsigned MaxN = 32;

  typedef logic [DefN-1:0][DefW-1:0] lane_data_t;

  function automatic int unsigned sw_of(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Rotate the low n bits right by amt: bit amt lands in position 0.
  function automatic logic [MaxN-1:0] rotr(input logic [MaxN-1:0] v,
                                           input int unsigned amt,
                                           input int unsigned n);
    logic [MaxN-1:0] r;
    int unsigned src;
    r = '0;
    for (int unsigned i = 0; i < MaxN; i++) begin
      if (i < n) begin
        src = i + amt;
        if (src >= n) src = src - n;
        r[i] = v[src];
      end
    end
    return r;
  endfunction

  // Inverse of rotr over the low n bits.
  function automatic logic [MaxN-1:0] rotl(input logic [MaxN-1:0] v,
                                           input int unsigned amt,
                                           input int unsigned n);
    logic [MaxN-1:0] r;
    int unsigned dst;
    r = '0;
    for (int unsigned i = 0; i < MaxN; i++) begin
      if (i < n) begin
        dst = i + amt;
        if (dst >= n) dst = dst - n;
        r[dst] = v[i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
  import rr_mux_arb_pkg::*;
#(
  parameter int unsigned N = DefN,
  localparam int unsigned SW = sw_of(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [SW-1:0] gnt_idx
);

  logic [MaxN-1:0] rot;
  logic [MaxN-1:0] sel;
  logic [MaxN-1:0] shifted;
  logic            found;
  int unsigned     pos;
  int unsigned     idx;

  always_comb begin
    rot     = rotr(MaxN'(req), 32'(ptr), N);
    sel     = '0;
    found   = 1'b0;
    pos     = 0;
    // Lowest set bit of the rotated vector is the highest-priority requester.
    for (int unsigned i = 0; i < N; i++) begin
      if (rot[i] && !found) begin
        found  = 1'b1;
        sel[i] = 1'b1;
        pos    = i;
      end
    end
    shifted = rotl(sel, 32'(ptr), N);
    gnt     = shifted[N-1:0];
    idx     = pos + 32'(ptr);
    if (idx >= N) idx = idx - N;
    gnt_idx = found ? SW'(idx) : '0;
  end

  logic unused_bits;
  assign unused_bits = ^{rot, shifted};

endmodule

// File: rtl/rr_mux_arbiter.sv
// N-lane round-robin arbiter feeding an AND-OR mux into a single registered output slot.
// Define RR_MUX_ARB_LOCK_EN to add req_lock, which keeps the grant on a lane across beats.
module rr_mux_arbiter
  import rr_mux_arb_pkg::*;
#(
  parameter int unsigned N = DefN,
  parameter int unsigned W = DefW,
  localparam int unsigned SW = sw_of(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        req_valid,
  input  logic [N-1:0][W-1:0] req_data,
`ifdef RR_MUX_ARB_LOCK_EN
  input  logic [N-1:0]        req_lock,
`endif
  output logic [N-1:0]        req_ready,
  output logic                out_valid,
  output logic [W-1:0]        out_data,
  output logic [SW-1:0]       out_src,
  input  logic                out_ready,
  output logic [N-1:0]        grant_onehot
);

  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [SW-1:0] out_src_q, out_src_d;
  logic [SW-1:0] ptr_q, ptr_d;

  logic [SW-1:0] gnt_idx;
  logic [W-1:0]  mux_data;
  logic          load_en;
  logic          accept;
  logic          hold_ptr;

  rr_pick #(
    .N(N)
  ) u_pick (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (grant_onehot),
    .gnt_idx (gnt_idx)
  );

  assign load_en   = !out_valid_q || out_ready;
  // rst_n gating keeps ready low while the slot is being cleared.
  assign req_ready = grant_onehot & {N{load_en & rst_n}};
  assign accept    = |req_ready;

  always_comb begin
    mux_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      mux_data = mux_data | (req_data[i] & {W{grant_onehot[i]}});
    end
  end

`ifdef RR_MUX_ARB_LOCK_EN
  assign hold_ptr = |(req_lock & grant_onehot);
`else
  assign hold_ptr = 1'b0;
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_data;
      out_src_d   = gnt_idx;
      if (hold_ptr) begin
        ptr_d = gnt_idx;
      end else if (gnt_idx == SW'(N - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = gnt_idx + SW'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

  grant_onehot0_a : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_onehot));

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter and sequencer in front of the parameterised AND-OR mux array (N lanes × W bits, OR-reduced to one lane).
- Shares a single W-bit output channel among N valid/ready requesters.
- Builds a one-hot grant, muxes the granted lane through the AND-OR structure and registers the result in a single output slot.
- Sits between N producer lanes and one downstream consumer.

Parameters:
- N, 4, number of requester lanes (≥2).
- W, 2, data width per lane.
- SW, $clog2(N), width of source-index output (derived, not overridden).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  N  per-lane request valid.
- req_data  input  [N-1:0][W-1:0]  packed lane data.
- req_ready  output  N  per-lane accept; at most one bit high.
- out_valid  output  1  output slot holds a beat.
- out_data  output  W  registered muxed data.
- out_src  output  SW  index of the lane that produced out_data.
- out_ready  input  1  consumer accepts beat.
- grant_onehot  output  N  current-cycle one-hot grant (combinational, debug/mux select).

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_src=0, rr pointer ptr=0. Lane 0 has first priority. Reset mid-operation drops the held beat; no req_ready while rst_n=0.
- load_en = !out_valid || out_ready. The slot accepts a new beat when empty or being drained in the same cycle.
- Grant search: first lane i with req_valid[i]=1 in order ptr, ptr+1, …, N-1, 0, …, ptr-1 (mod N). grant_onehot is that lane, or 0 if none.
- req_ready = grant_onehot & {N{load_en}}. Combinational from req_valid/out_ready. Requesters must not make valid depend on ready.
- Handshake on lane g (req_valid[g] && req_ready[g]) causes, on the next edge:
  - out_data <= OR over i of (req_data[i] & {W{grant_onehot[i]}})
  - out_src <= g
  - out_valid <= 1
  - ptr <= (g+1) mod N; wrap N-1→0.
- Latency: request to out_valid is 1 cycle. Throughput is 1 beat/cycle while out_ready=1.
- out_ready=1 with no grant: out_valid <= 0. out_data and out_src hold their last values.
- Stall (out_valid=1, out_ready=0): out_* hold stable, req_ready=0, ptr holds.
- Simultaneous drain and load in the same cycle is legal and out_valid stays 1.
- No requests: ptr unchanged.
- Fairness: a continuously valid lane waits at most N-1 grants.
- grant_onehot has zero or one bit set; an assertion checks $onehot0.

Optional Feature:
- Macro RR_MUX_ARB_LOCK_EN.
- When defined:
  - Extra port req_lock input N.
  - If the accepted beat on lane g has req_lock[g]=1, ptr <= g (the grant sticks to g for the next beat).
  - The lock releases on the first accepted beat from g with req_lock[g]=0, after which ptr <= g+1.
  - If g drops req_valid while locked, the search proceeds normally from ptr=g.
- When undefined: the port is absent and behaviour is pure round-robin as above.

Decomposition:
- Package rr_mux_arb_pkg:
  - default N, W localparams
  - function for SW
  - typedef of the packed lane array [N-1:0][W-1:0]
  - rotate-left / rotate-right helper functions for the priority search.
- Sub-module rr_pick: combinational one-hot round-robin picker (inputs req N, ptr SW; outputs gnt N, gnt_idx SW).
- The AND-OR data mux stays inline in rr_mux_arbiter.

Test Plan:
- Reset then req_valid=4'b1111, data={2'b00,2'b01,2'b10,2'b11} (lane3..0), out_ready=1 → beats out_src 0,1,2,3,0 on consecutive cycles; out_data 11,10,01,00,11.
- req_valid=4'b0101, out_ready=1, ptr=0 → grants alternate lane0, lane2; lane1/lane3 req_ready stay 0.
- Beat held with out_ready=0 for 3 cycles → out_data/out_src stable, req_ready=0000; on release next beat follows with no gap.
- Single lane 3 valid after lane 3 granted (ptr wraps 3→0) → lane 3 granted again next cycle; out_src=3.
- rst_n pulsed low while out_valid=1 → out_valid=0 immediately (async), ptr=0 after release, first grant lane 0.
- With RR_MUX_ARB_LOCK_EN: lanes 1 and 2 valid, lane1 req_lock=1 for 3 beats then 0 → out_src 1,1,1,1,2.
